// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter for the shared native memory bus.
// Define ARB_TIMEOUT_EN to build the watchdog that terminates hung transactions.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   // master 0 (CPU)
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   // master 1 (DMA)
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   // shared slave bus
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   // status; grant doubles as the visible FSM state (00 idle, 01 busy0, 10 busy1)
   output logic [1:0]  grant,
   output logic        timeout_flag
);

   // Handshake: a master holds valid and its request stable until it sees ready
   // for one cycle; the grant ends on the edge after ready, an abort or expiry.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY0 = 2'd1,
      ST_BUSY1 = 2'd2
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
   end

   state_t      r_state;
   state_t      w_next_state;
   logic        r_last_grant;
   logic        w_next_last;

   logic        w_busy;
   logic        w_sel1;
   logic        w_req_valid;
   logic        w_req_instr;
   logic [31:0] w_req_addr;
   logic [31:0] w_req_wdata;
   logic [3:0]  w_req_wstrb;
   logic        w_rsp_ready;
   logic [31:0] w_rsp_rdata;
   logic        w_expire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
      end else begin
         r_state      <= w_next_state;
         r_last_grant <= w_next_last;
      end
   end

   // Request mux of whichever master currently owns the bus
   always_comb begin
      w_busy      = (r_state == ST_BUSY0) || (r_state == ST_BUSY1);
      w_sel1      = (r_state == ST_BUSY1);
      w_req_valid = 1'b0;
      w_req_instr = 1'b0;
      w_req_addr  = 32'd0;
      w_req_wdata = 32'd0;
      w_req_wstrb = 4'd0;
      if (r_state == ST_BUSY0) begin
         w_req_valid = m0_valid;
         w_req_instr = m0_instr;
         w_req_addr  = m0_addr;
         w_req_wdata = m0_wdata;
         w_req_wstrb = m0_wstrb;
      end else if (r_state == ST_BUSY1) begin
         w_req_valid = m1_valid;
         w_req_instr = m1_instr;
         w_req_addr  = m1_addr;
         w_req_wdata = m1_wdata;
         w_req_wstrb = m1_wstrb;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_last  = r_last_grant;
      case (r_state)
         ST_IDLE: begin
            // on contention the master that was not served last wins
            if (m0_valid && (!m1_valid || r_last_grant)) begin
               w_next_state = ST_BUSY0;
               w_next_last  = 1'b0;
            end else if (m1_valid) begin
               w_next_state = ST_BUSY1;
               w_next_last  = 1'b1;
            end
         end
         ST_BUSY0, ST_BUSY1: begin
            if (s_ready || !w_req_valid || w_expire) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rsp_ready  = w_busy && (s_ready || w_expire);
      w_rsp_rdata  = 32'd0;
      if (w_busy) begin
         w_rsp_rdata = w_expire ? TIMEOUT_RDATA : s_rdata;
      end

      s_valid  = w_req_valid && !w_expire;
      s_instr  = w_req_instr;
      s_addr   = w_req_addr;
      s_wdata  = w_req_wdata;
      s_wstrb  = w_req_wstrb;

      m0_ready = 1'b0;
      m0_rdata = 32'd0;
      m1_ready = 1'b0;
      m1_rdata = 32'd0;
      grant    = 2'b00;
      if (w_busy && !w_sel1) begin
         m0_ready = w_rsp_ready;
         m0_rdata = w_rsp_rdata;
         grant    = 2'b01;
      end else if (w_busy && w_sel1) begin
         m1_ready = w_rsp_ready;
         m1_rdata = w_rsp_rdata;
         grant    = 2'b10;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

   logic [15:0] r_cnt;
   logic        r_timeout_flag;

   // r_cnt holds the ready-less BUSY cycles already elapsed; IDLE always
   // precedes BUSY, so clearing it there clears it on every entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt          <= 16'd0;
         r_timeout_flag <= 1'b0;
      end else begin
         if (!w_busy) begin
            r_cnt <= 16'd0;
         end else if (!s_ready) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (w_expire) begin
            r_timeout_flag <= 1'b1;
         end
      end
   end

   // s_ready on the expiry cycle wins and the transaction completes normally
   assign w_expire     = w_busy && w_req_valid && !s_ready &&
                         ((r_cnt + 16'd1) == LP_TIMEOUT);
   assign timeout_flag = r_timeout_flag;
`else
   assign w_expire     = 1'b0;
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single native memory bus (memory, gpio, prng, uartTx, timer behind the address decoder) between the picorv32 CPU and a second bus master such as a DMA engine. It arbitrates round-robin at transaction boundaries and holds the grant until the slave side returns ready. An optional watchdog terminates hung transactions.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: BUSY-state cycles without s_ready before forced termination. Used only with ARB_TIMEOUT_EN. Legal range 1..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports:
- clk  in  1  system clock (CLOCK_100 domain).
- reset  in  1  asynchronous, active-high reset.
- m0_valid / m0_instr  in  1 / 1  master 0 (CPU) request and instruction-fetch flag.
- m0_addr / m0_wdata  in  32 / 32  master 0 address and write data.
- m0_wstrb  in  4  master 0 byte strobes; 0 means read.
- m0_rdata  out  32  master 0 read data.
- m0_ready  out  1  master 0 completion strobe.
- m1_*  same set as m0_*  master 1 (DMA).
- s_valid / s_instr  out  1 / 1  request and fetch flag to the shared bus.
- s_addr / s_wdata  out  32 / 32  shared-bus address and write data.
- s_wstrb  out  4  shared-bus byte strobes.
- s_rdata  in  32  shared-bus read data.
- s_ready  in  1  shared-bus completion strobe.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_flag  out  1  sticky flag: a transaction timed out.

## Operation
- FSM states: IDLE, BUSY0, BUSY1. Registered state, plus a registered last_grant bit (0 = m0 last served).
- IDLE:
  - If only one mX_valid is high, go to BUSYX.
  - If both are high, grant the master that was not last_grant, then update last_grant.
  - If neither is high, stay in IDLE.
- BUSYx:
  - s_* outputs are a combinational mux of the granted master's request signals.
  - mx_rdata = s_rdata and mx_ready = s_ready for the granted master only.
  - The other master sees ready = 0 and rdata = 0.
- Termination, from BUSYx to IDLE on the cycle after any of:
  - s_ready = 1;
  - the granted mx_valid drops (protocol abort);
  - watchdog expiry.
- Masters follow the picorv32 rule: hold valid and the request stable until ready, then drop valid or present a new request. A master's new request always passes through IDLE, so every transaction costs at least one arbitration cycle. This gives the other master a fair chance.
- In IDLE, all s_* outputs, both mX_ready and both mX_rdata are 0.
- grant = 2'b01 in BUSY0, 2'b10 in BUSY1, 2'b00 in IDLE.
- Reset, asynchronous:
  - state = IDLE, last_grant = 1 (so m0 wins the first contested cycle), timeout_flag = 0.
  - All outputs go to 0 immediately, including mid-transaction. The interrupted transaction is dropped and never reported.

## Timing
- Request latency: mX_valid rising in cycle N while in IDLE gives s_valid = 1 in cycle N+1.
- Completion latency: s_ready in cycle M gives mX_ready = 1 in cycle M, combinationally. The FSM is in IDLE in cycle M+1.
- Minimum transaction: 2 cycles (arbitrate + one-cycle slave). Back-to-back requests from the same master are separated by one IDLE cycle.
- Contention: with both valids held high, grants alternate m0, m1, m0, and so on. No master waits more than one foreign transaction.
- s_ready asserted while in IDLE is ignored.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSYx and increments each BUSY cycle without s_ready.
  - When the count equals TIMEOUT_CYCLES, the arbiter drives mx_ready = 1 and mx_rdata = TIMEOUT_RDATA for that cycle, forces s_valid = 0 that cycle, and sets timeout_flag.
  - The FSM returns to IDLE. timeout_flag clears only on reset.
  - If s_ready and expiry coincide, s_ready wins: normal data is returned and the flag is not set.
- ARB_TIMEOUT_EN undefined:
  - No counter is built and timeout_flag is tied to 0.
  - A hung slave stalls the granted master, and the other master waits indefinitely.

## Test plan
- Single master: m0 reads address 0x100, slave returns 0x12345678 with ready 3 cycles after s_valid → m0_rdata = 0x12345678 with m0_ready for one cycle, grant = 01 throughout, m1_ready = 0.
- Contention: m0 and m1 both raise valid in the first cycle after reset → m0 is served first, then m1 (grant 01, 00, 10). Repeated contention alternates grants strictly.
- Write pass-through: m1 writes 0xA5A5A5A5 to 0x200 with wstrb 0011 → s_addr, s_wdata and s_wstrb match exactly while grant = 10, and m0 sees no ready.
- Reset mid-transaction: assert reset while in BUSY0 → s_valid, grant and m0_ready go to 0 asynchronously. After release, state is IDLE and the first contested grant goes to m0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): the slave never asserts ready → m0_ready pulses on BUSY cycle 8 with rdata 0xDEADBEEF, and timeout_flag stays 1.
- Timeout coincidence (ARB_TIMEOUT_EN): s_ready arrives exactly on cycle 8 → real data is returned and timeout_flag remains 0.
